// File: rtl/sum_group_accumulator.sv
// sum_group_accumulator: sums groups of incoming sum values and emits one total per group.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_vld/in_rdy       input handshake; in_data is an unsigned sum, in_last closes the group
//   out_vld/out_rdy     output handshake; out_data is the group total, out_cnt its item count
module sum_group_accumulator #(
    parameter int width = 9,
    parameter int n = 4,
    localparam int cw = $clog2(n + 1),
    localparam int aw = width + $clog2(n)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [width-1:0] in_data,
    input  logic             in_last,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [aw-1:0]    out_data,
    output logic [cw-1:0]    out_cnt
);
    logic [aw-1:0] acc;
    logic [cw-1:0] cnt;
    logic          candidate;
    logic          accept;
    logic          closing;
    logic [aw-1:0] sum;

    // The n-th item always closes, so cnt never reaches n between edges.
    assign candidate = in_last | (cnt == cw'(n - 1));
    // Only a closing item needs the output register free (or draining this cycle).
    assign in_rdy    = ~candidate | ~out_vld | out_rdy;
    assign accept    = in_vld & in_rdy;
    assign closing   = accept & candidate;
    assign sum       = acc + aw'(in_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
            out_cnt  <= '0;
        end else begin
            if (closing) begin
                out_data <= sum;
                out_cnt  <= cnt + cw'(1);
                out_vld  <= 1'b1;
                acc      <= '0;
                cnt      <= '0;
            end else begin
                if (accept) begin
                    acc <= sum;
                    cnt <= cnt + cw'(1);
                end
                if (out_vld & out_rdy)
                    out_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sum_group_accumulator.sv
// tb_sum_group_accumulator: randomized and directed checks of sum_group_accumulator against a group model.
// Ports: none (drives clk/rst and the DUT handshakes internally).
module tb_sum_group_accumulator;
    localparam int N = 4;
    localparam int W = 9;
    localparam int AW = W + $clog2(N);
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic          out_vld;
    logic          out_rdy = 1'b0;
    logic [AW-1:0] out_data;
    logic [CW-1:0] out_cnt;

    int chk = 0;
    int pass = 0;
    bit mon_en = 1'b0;

    // Reference model: accepted items accumulate into an open group; closed groups queue
    // until the consumer takes them.
    int m_sum = 0;
    int m_cnt = 0;
    int q_sum[$];
    int q_cnt[$];
    bit held = 1'b0;
    int h_data = 0;
    int h_cnt = 0;
    bit ev;
    bit er;

    sum_group_accumulator #(.width(W), .n(N)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .in_last(in_last), .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            ev = q_sum.size() != 0;
            chk++;
            if (out_vld !== ev) $display("FAIL mon_out_vld: got %0b expected %0b", out_vld, ev);
            else pass++;
            er = !(in_last || m_cnt == N - 1) || !ev || out_rdy;
            chk++;
            if (in_rdy !== er) $display("FAIL mon_in_rdy: got %0b expected %0b", in_rdy, er);
            else pass++;
            if (held) begin
                chk++;
                if (out_data !== AW'(h_data) || out_cnt !== CW'(h_cnt))
                    $display("FAIL mon_stable: got %0d/%0d expected %0d/%0d", out_data, out_cnt, h_data, h_cnt);
                else pass++;
            end
            held = out_vld && !out_rdy;
            h_data = out_data;
            h_cnt = out_cnt;
            if (out_vld && out_rdy && ev) begin
                chk++;
                if (out_data !== AW'(q_sum[0]) || out_cnt !== CW'(q_cnt[0]))
                    $display("FAIL mon_total: got %0d/%0d expected %0d/%0d", out_data, out_cnt, q_sum[0], q_cnt[0]);
                else pass++;
                void'(q_sum.pop_front());
                void'(q_cnt.pop_front());
            end
            if (in_vld && in_rdy) begin
                m_sum += int'(in_data);
                m_cnt++;
                if (in_last || m_cnt == N) begin
                    q_sum.push_back(m_sum);
                    q_cnt.push_back(m_cnt);
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        chk++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
        else pass++;
    endtask

    task automatic send(input int d, input bit l, output int waits);
        in_vld = 1'b1;
        in_data = W'(d);
        in_last = l;
        waits = 0;
        forever begin
            @(negedge clk);
            if (in_rdy) break;
            waits++;
            if (waits > 50) begin
                chk++;
                $display("FAIL send_timeout: got in_rdy 0 expected 1");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        in_vld = 1'b0;
        in_last = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        #3;
        check("reset_in_rdy", int'(in_rdy), 1);
        check("reset_out_vld", int'(out_vld), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_out_cnt", int'(out_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_back_to_back;
        int w;
        out_rdy = 1'b1;
        send(10, 0, w);
        send(20, 0, w);
        send(30, 0, w);
        send(40, 0, w);
        check("b2b_vld", int'(out_vld), 1);
        check("b2b_data", int'(out_data), 100);
        check("b2b_cnt", int'(out_cnt), 4);
        idle(1);
        check("b2b_vld_drop", int'(out_vld), 0);
        idle(1);
    endtask

    task automatic test_last_groups;
        int w;
        int tw = 0;
        out_rdy = 1'b1;
        send(5, 0, w);
        tw += w;
        send(7, 1, w);
        tw += w;
        check("last_data2", int'(out_data), 12);
        check("last_cnt2", int'(out_cnt), 2);
        send(3, 1, w);
        tw += w;
        check("last_data1", int'(out_data), 3);
        check("last_cnt1", int'(out_cnt), 1);
        check("last_no_wait", tw, 0);
        idle(2);
    endtask

    task automatic test_backpressure;
        int w;
        out_rdy = 1'b0;
        for (int i = 1; i <= 7; i++) send(i, 0, w);
        in_vld = 1'b1;
        in_data = 8;
        in_last = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_stall_rdy", int'(in_rdy), 0);
            check("bp_hold_data", int'(out_data), 10);
            @(posedge clk);
            #1;
        end
        out_rdy = 1'b1;
        @(negedge clk);
        check("bp_release_rdy", int'(in_rdy), 1);
        @(posedge clk);
        #1;
        check("bp_new_vld", int'(out_vld), 1);
        check("bp_new_data", int'(out_data), 26);
        check("bp_new_cnt", int'(out_cnt), 4);
        idle(2);
        check("bp_drained", int'(out_vld), 0);
    endtask

    task automatic test_max;
        int w;
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) send(511, 0, w);
        check("max_data", int'(out_data), 2044);
        check("max_cnt", int'(out_cnt), 4);
        idle(2);
    endtask

    task automatic test_continuous;
        int w;
        int tw = 0;
        int a;
        int b;
        out_rdy = 1'b1;
        for (int g = 0; g < 20; g++) begin
            a = int'($urandom_range(0, 511));
            b = int'($urandom_range(0, 511));
            send(a, 0, w);
            tw += w;
            send(b, 1, w);
            tw += w;
            check("cont_data", int'(out_data), a + b);
            check("cont_cnt", int'(out_cnt), 2);
        end
        check("cont_no_wait", tw, 0);
        idle(2);
    endtask

    task automatic test_async_reset;
        int w;
        out_rdy = 1'b0;
        send(9, 1, w);
        send(30, 0, w);
        send(30, 0, w);
        in_vld = 1'b0;
        #1;
        rst = 1'b1;
        m_sum = 0;
        m_cnt = 0;
        q_sum.delete();
        q_cnt.delete();
        held = 1'b0;
        #1;
        check("arst_out_vld", int'(out_vld), 0);
        check("arst_out_cnt", int'(out_cnt), 0);
        check("arst_in_rdy", int'(in_rdy), 1);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) send(1, 0, w);
        check("arst_next_data", int'(out_data), 4);
        check("arst_next_cnt", int'(out_cnt), 4);
        idle(2);
    endtask

    task automatic test_random;
        for (int c = 0; c < 400; c++) begin
            in_vld = ($urandom_range(0, 3) != 0);
            in_data = W'($urandom_range(0, 511));
            in_last = ($urandom_range(0, 3) == 0);
            out_rdy = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        out_rdy = 1'b1;
        idle(4);
        check("rand_drained", q_sum.size(), 0);
        check("rand_out_vld", int'(out_vld), 0);
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_last_groups;
        test_backpressure;
        test_max;
        test_continuous;
        test_async_reset;
        test_random;
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
